// File: rtl/div16u8_seq.sv
// Sequential restoring radix-2 unsigned divider (DW-bit dividend, VW-bit divisor), valid/ready both sides.
// Define DIV_APPROX_EN to skip the low APPROX_BITS quotient bits (shorter latency, r forced 0).
module div16u8_seq #(
  parameter int DW          = 16,
  parameter int VW          = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          div_zero
);

`ifdef DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int ITERS = APPROX_EN ? (DW - APPROX_BITS) : DW;
  localparam int QW    = ITERS - 1;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] a_reg;
  logic [VW-1:0] b_reg;
  logic [VW-1:0] rem;
  logic [QW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          dz_pend;

  logic [VW:0]   p;
  logic [VW:0]   sub;
  logic          qbit;
  logic [VW-1:0] rem_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The partial remainder is always below the divisor, so p < 2*b and a
  // non-borrowing subtract leaves bit VW clear; that bit is the borrow flag.
  assign p        = {rem, a_reg[DW-1]};
  assign sub      = p - {1'b0, b_reg};
  assign qbit     = ~sub[VW];
  assign rem_next = qbit ? sub[VW-1:0] : p[VW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      dz_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            dz_pend <= (b == '0);
            state   <= BUSY;
          end
        end

        BUSY: begin
          if (dz_pend) begin
            q        <= '1;
            r        <= a_reg[VW-1:0];
            div_zero <= 1'b1;
            state    <= DONE;
          end else begin
            a_reg <= a_reg << 1;
            rem   <= rem_next;
            quo   <= {quo[QW-2:0], qbit};
            cnt   <= cnt + CW'(1);
            // Final iteration: the last quotient bit goes straight into q.
            if (cnt == LAST) begin
`ifdef DIV_APPROX_EN
              q <= {quo, qbit, {APPROX_BITS{1'b0}}};
              r <= '0;
`else
              q <= {quo, qbit};
              r <= rem_next;
`endif
              div_zero <= 1'b0;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16u8_seq.sv
// Directed self-checking bench for div16u8_seq; build with DIV_APPROX_EN to check the approximate mode.
module tb_div16u8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_zero;

  int n_vec = 0;
  int n_err = 0;

  div16u8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Stimulus only: accept one operand pair and count edges until out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [7:0] tb_v, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hA5A5;
    b = 8'h3C;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (q !== 16'd0) begin n_err++; $display("[TB] FAIL reset_q got %0d want 0", q); end
    n_vec++; if (r !== 8'd0) begin n_err++; $display("[TB] FAIL reset_r got %0d want 0", r); end
    n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("[TB] FAIL reset_div_zero got %b want 0", div_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    run_op(16'd1000, 8'd7, lat);
    n_vec++; if (lat !== 16) begin n_err++; $display("[TB] FAIL basic_latency got %0d want 16", lat); end
    n_vec++; if (q !== 16'd142) begin n_err++; $display("[TB] FAIL basic_q got %0d want 142", q); end
    n_vec++; if (r !== 8'd6) begin n_err++; $display("[TB] FAIL basic_r got %0d want 6", r); end
    n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("[TB] FAIL basic_div_zero got %b want 0", div_zero); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_valid_width got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL basic_idle got %b want 1", in_ready); end
  endtask

  task automatic test_edges;
    logic [15:0] va [5] = '{16'd65535, 16'd200, 16'd65535, 16'd12345, 16'd256};
    logic [7:0]  vb [5] = '{8'd255,    8'd201,  8'd1,      8'd100,    8'd16};
    logic [15:0] eq [5] = '{16'd257,   16'd0,   16'd65535, 16'd123,   16'd16};
    logic [7:0]  er [5] = '{8'd0,      8'd200,  8'd0,      8'd45,     8'd0};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], lat);
      n_vec++; if (lat !== 16) begin n_err++; $display("[TB] FAIL edge%0d_latency got %0d want 16", i, lat); end
      n_vec++; if (q !== eq[i]) begin n_err++; $display("[TB] FAIL edge%0d_q got %0d want %0d", i, q, eq[i]); end
      n_vec++; if (r !== er[i]) begin n_err++; $display("[TB] FAIL edge%0d_r got %0d want %0d", i, r, er[i]); end
      n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("[TB] FAIL edge%0d_div_zero got %b want 0", i, div_zero); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] va [2] = '{16'd5, 16'h1234};
    logic [7:0]  er [2] = '{8'd5, 8'h34};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], 8'd0, lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("[TB] FAIL dz%0d_latency got %0d want 1", i, lat); end
      n_vec++; if (q !== 16'hFFFF) begin n_err++; $display("[TB] FAIL dz%0d_q got %h want ffff", i, q); end
      n_vec++; if (r !== er[i]) begin n_err++; $display("[TB] FAIL dz%0d_r got %h want %h", i, r, er[i]); end
      n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("[TB] FAIL dz%0d_flag got %b want 1", i, div_zero); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_op(16'd50000, 8'd3, lat);
    n_vec++; if (lat !== 16) begin n_err++; $display("[TB] FAIL bp_latency got %0d want 16", lat); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'(i * 111);
      b = 8'(i + 1);
      @(posedge clk); #1;
      n_vec++; if (q !== 16'd16666) begin n_err++; $display("[TB] FAIL bp_q_hold%0d got %0d want 16666", i, q); end
      n_vec++; if (r !== 8'd2) begin n_err++; $display("[TB] FAIL bp_r_hold%0d got %0d want 2", i, r); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid%0d got %b want 1", i, out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); end
    n_vec++; if (q !== 16'd16666) begin n_err++; $display("[TB] FAIL bp_q_retain got %0d want 16666", q); end
    run_op(16'd100, 8'd9, lat);
    n_vec++; if (lat !== 16) begin n_err++; $display("[TB] FAIL bp_next_latency got %0d want 16", lat); end
    n_vec++; if (q !== 16'd11) begin n_err++; $display("[TB] FAIL bp_next_q got %0d want 11", q); end
    n_vec++; if (r !== 8'd1) begin n_err++; $display("[TB] FAIL bp_next_r got %0d want 1", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    out_ready = 1'b1;
    a = 16'd1000;
    b = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_valid got %b want 0", out_valid); end
    n_vec++; if (q !== 16'd0) begin n_err++; $display("[TB] FAIL rmid_q got %0d want 0", q); end
    n_vec++; if (r !== 8'd0) begin n_err++; $display("[TB] FAIL rmid_r got %0d want 0", r); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_in_ready got %b want 1", in_ready); end
    run_op(16'd40001, 8'd199, lat);
    n_vec++; if (lat !== 16) begin n_err++; $display("[TB] FAIL rmid_next_latency got %0d want 16", lat); end
    n_vec++; if (q !== 16'd201) begin n_err++; $display("[TB] FAIL rmid_next_q got %0d want 201", q); end
    n_vec++; if (r !== 8'd2) begin n_err++; $display("[TB] FAIL rmid_next_r got %0d want 2", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_approx;
    int lat;
    logic [15:0] ta;
    logic [7:0]  tbv;
    logic [15:0] exp_q;
    out_ready = 1'b1;
    run_op(16'd1000, 8'd7, lat);
    n_vec++; if (lat !== 12) begin n_err++; $display("[TB] FAIL approx_latency got %0d want 12", lat); end
    n_vec++; if (q !== 16'd128) begin n_err++; $display("[TB] FAIL approx_q got %0d want 128", q); end
    n_vec++; if (r !== 8'd0) begin n_err++; $display("[TB] FAIL approx_r got %0d want 0", r); end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      ta = 16'($urandom_range(0, 65535));
      tbv = 8'($urandom_range(1, 255));
      exp_q = 16'((32'(ta >> 4) / 32'(tbv)) << 4);
      run_op(ta, tbv, lat);
      n_vec++; if (q !== exp_q) begin n_err++; $display("[TB] FAIL approx_sweep%0d a=%0d b=%0d got %0d want %0d", i, ta, tbv, q, exp_q); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
`ifdef DIV_APPROX_EN
    test_div_zero();
    test_approx();
`else
    test_basic();
    test_edges();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
